// File: rtl/axis_traffic_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_traffic_gen_pkg
// Purpose  : Shared types and PRBS31 constants for the AXIS traffic generator.
// Revision : 1.0 - initial release
// ============================================================================
package axis_traffic_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int          c_prbs_width = 31;
    localparam int          c_prbs_tap_a = 30;  // x^31 term
    localparam int          c_prbs_tap_b = 27;  // x^28 term
    localparam logic [30:0] c_prbs_seed  = '1;

    function automatic logic [30:0] prbs31_next(input logic [30:0] s, input logic load);
        return load ? c_prbs_seed : {s[29:0], s[c_prbs_tap_a] ^ s[c_prbs_tap_b]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_traffic_gen_prbs_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : prbs_lfsr
// Purpose  : Fibonacci PRBS31 generator, replicated across DATA_WIDTH bits.
//            Compiled only when AXIS_TRAFFIC_GEN_PRBS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef AXIS_TRAFFIC_GEN_PRBS_EN
module prbs_lfsr
    import axis_traffic_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_step,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [c_prbs_width-1:0] r_lfsr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_lfsr <= '0;
        end else if (i_load || i_step) begin
            r_lfsr <= prbs31_next(r_lfsr, i_load);
        end
    end

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_rep
        assign o_data[i] = r_lfsr[i % c_prbs_width];
    end

endmodule
`endif
`default_nettype wire

// File: rtl/axis_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : axis_traffic_gen
// Purpose  : AXI-Stream packet source with programmable length, gap and count.
//            Define AXIS_TRAFFIC_GEN_PRBS_EN for a PRBS31 payload.
// Revision : 1.0 - initial release
// ============================================================================
module axis_traffic_gen
    import axis_traffic_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [LEN_WIDTH-1:0]  i_pkt_len,
    input  logic [LEN_WIDTH-1:0]  i_gap_len,
    input  logic [LEN_WIDTH-1:0]  i_pkt_count,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic                  o_tlast,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [LEN_WIDTH-1:0]  o_pkt_sent
);

    state_t               r_state;
    state_t               w_state_next;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_gap;
    logic [LEN_WIDTH-1:0] r_count;
    logic [LEN_WIDTH-1:0] r_beat;
    logic [LEN_WIDTH-1:0] r_gap_cnt;
    logic [LEN_WIDTH-1:0] r_pkt_sent;
    logic                 r_tvalid;
    logic                 r_tlast;
    logic                 r_done;
    logic                 r_busy;

    logic                 w_tvalid_next;
    logic                 w_tlast_next;
    logic                 w_done_next;
    logic [LEN_WIDTH-1:0] w_len_eff;
    logic [LEN_WIDTH-1:0] w_len_m1;
    logic [LEN_WIDTH-1:0] w_beat_inc;
    logic [LEN_WIDTH-1:0] w_pkt_sent_inc;
    logic                 w_start;
    logic                 w_hs;
    logic                 w_last_beat;
    logic                 w_run_done;
    logic                 w_gap_over;

    assign w_len_eff      = (i_pkt_len == '0) ? LEN_WIDTH'(1) : i_pkt_len;
    assign w_start        = (r_state == IDLE) && i_en;
    assign w_hs           = (r_state == SEND) && r_tvalid && i_tready;
    assign w_len_m1       = r_len - 1'b1;
    assign w_beat_inc     = r_beat + 1'b1;
    assign w_last_beat    = (r_beat == w_len_m1);
    assign w_pkt_sent_inc = r_pkt_sent + 1'b1;
    assign w_run_done     = (r_count != '0) && (w_pkt_sent_inc == r_count);
    assign w_gap_over     = (r_gap_cnt == r_gap);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (i_en) w_state_next = SEND;
            SEND: begin
                if (w_hs && w_last_beat) begin
                    if (w_run_done || !i_en) w_state_next = IDLE;
                    else if (r_gap == '0)    w_state_next = SEND;
                    else                     w_state_next = GAP;
                end
            end
            GAP:  if (w_gap_over) w_state_next = i_en ? SEND : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead and registered below.
    always_comb begin
        w_tvalid_next = (w_state_next == SEND);
        w_done_next   = w_hs && w_last_beat && w_run_done;
        w_tlast_next  = 1'b0;
        case (r_state)
            IDLE: w_tlast_next = (w_len_eff == LEN_WIDTH'(1));
            SEND: begin
                if (!w_hs)            w_tlast_next = r_tlast;
                else if (w_last_beat) w_tlast_next = (r_len == LEN_WIDTH'(1));
                else                  w_tlast_next = (w_beat_inc == w_len_m1);
            end
            GAP:  w_tlast_next = (r_len == LEN_WIDTH'(1));
            default: w_tlast_next = 1'b0;
        endcase
        if (w_state_next != SEND) w_tlast_next = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_len      <= '0;
            r_gap      <= '0;
            r_count    <= '0;
            r_beat     <= '0;
            r_gap_cnt  <= '0;
            r_pkt_sent <= '0;
        end else begin
            r_tvalid <= w_tvalid_next;
            r_tlast  <= w_tlast_next;
            r_done   <= w_done_next;
            r_busy   <= (w_state_next != IDLE);
            if (w_start) begin
                r_len      <= w_len_eff;
                r_gap      <= i_gap_len;
                r_count    <= i_pkt_count;
                r_pkt_sent <= '0;
                r_beat     <= '0;
            end else if (w_hs) begin
                if (w_last_beat) begin
                    r_beat     <= '0;
                    r_pkt_sent <= w_pkt_sent_inc;
                    r_gap_cnt  <= LEN_WIDTH'(1);
                end else begin
                    r_beat <= w_beat_inc;
                end
            end else if (r_state == GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
        end
    end

`ifdef AXIS_TRAFFIC_GEN_PRBS_EN
    prbs_lfsr #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_prbs (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_start),
        .i_step  (w_hs),
        .o_data  (o_tdata)
    );
`else
    logic [DATA_WIDTH-1:0] r_payload;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || w_start) begin
            r_payload <= '0;
        end else if (w_hs) begin
            r_payload <= r_payload + 1'b1;
        end
    end

    assign o_tdata = r_payload;
`endif

    assign o_tvalid   = r_tvalid;
    assign o_tlast    = r_tlast;
    assign o_done     = r_done;
    assign o_busy     = r_busy;
    assign o_pkt_sent = r_pkt_sent;

endmodule
`default_nettype wire

// File: tb/tb_axis_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_traffic_gen
// Purpose  : Scoreboard bench for axis_traffic_gen (AXIS_TRAFFIC_GEN_PRBS_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_traffic_gen;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [LW-1:0] pkt_len = '0;
    logic [LW-1:0] gap_len = '0;
    logic [LW-1:0] pkt_count = '0;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready = 1'b0;
    logic          tlast;
    logic          busy;
    logic          done;
    logic [LW-1:0] pkt_sent;

    always #5 clk = ~clk;

    axis_traffic_gen #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_pkt_len   (pkt_len),
        .i_gap_len   (gap_len),
        .i_pkt_count (pkt_count),
        .o_tdata     (tdata),
        .o_tvalid    (tvalid),
        .i_tready    (tready),
        .o_tlast     (tlast),
        .o_busy      (busy),
        .o_done      (done),
        .o_pkt_sent  (pkt_sent)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks   = 0;
    int    n_fail     = 0;
    int    hs_total   = 0;
    int    done_seen  = 0;
    int    cur_gap    = 0;
    int    ready_mode = 0;  // 0: always ready, 1: random, 2: toggle
`ifdef AXIS_TRAFFIC_GEN_PRBS_EN
    bit    pbits[$];
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Expected beats of a run: payload index k, tlast on every len-th beat.
    task automatic push_run(input int len, input int npkts);
        int    le;
        beat_t b;
        le = (len == 0) ? 1 : len;
`ifdef AXIS_TRAFFIC_GEN_PRBS_EN
        pbits.delete();
        repeat (31) pbits.push_back(1'b1);
`endif
        for (int k = 0; k < le * npkts; k++) begin
`ifdef AXIS_TRAFFIC_GEN_PRBS_EN
            for (int i = 0; i < DW; i++) b.data[i] = pbits[pbits.size() - 1 - (i % 31)];
            pbits.push_back(pbits[pbits.size() - 31] ^ pbits[pbits.size() - 28]);
`else
            b.data = DW'(k);
`endif
            b.last = ((k % le) == le - 1);
            exp_q.push_back(b);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tready = 1'b1;
                1:       tready = 1'($urandom_range(0, 1));
                default: tready = ~tready;
            endcase
        end
    end

    // Monitor: pops the scoreboard on handshakes, checks stalls and gaps.
    initial begin
        bit            prev_stall = 1'b0;
        bit            after_last = 1'b0;
        int            idle_cnt   = 0;
        logic [DW-1:0] prev_data  = '0;
        logic          prev_last  = 1'b0;
        beat_t         b;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                after_last = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 64'(tvalid), 64'(1));
                    chk("stall_data", 64'(tdata), 64'(prev_data));
                    chk("stall_last", 64'(tlast), 64'(prev_last));
                end
                if (after_last) begin
                    if (!tvalid) idle_cnt++;
                    else begin
                        chk("gap_len", 64'(idle_cnt), 64'(cur_gap));
                        after_last = 1'b0;
                    end
                end
                if (tvalid && tready) begin
                    hs_total++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data %0h with nothing expected", tdata);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_data", 64'(tdata), 64'(b.data));
                        chk("beat_last", 64'(tlast), 64'(b.last));
                        if (tlast && exp_q.size() > 0) begin
                            after_last = 1'b1;
                            idle_cnt   = 0;
                        end
                    end
                end
                prev_stall = tvalid && !tready;
                prev_data  = tdata;
                prev_last  = tlast;
                if (done) done_seen++;
            end
        end
    end

    task automatic run_bounded(input int len, input int gap, input int count,
                               input int mode, input bit scramble);
        int d0;
        bit got;
        bit prev_last_hs;
        @(negedge clk);
        ready_mode = mode;
        cur_gap    = gap;
        pkt_len    = LW'(len);
        gap_len    = LW'(gap);
        pkt_count  = LW'(count);
        push_run(len, count);
        d0 = done_seen;
        en = 1'b1;
        @(negedge clk);
        chk("start_valid", 64'(tvalid), 64'(1));
        chk("start_busy", 64'(busy), 64'(1));
        if (scramble) begin
            pkt_len   = LW'($urandom);
            gap_len   = LW'($urandom);
            pkt_count = LW'($urandom);
        end
        got = 1'b0;
        prev_last_hs = tvalid && tready && tlast;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            prev_last_hs = tvalid && tready && tlast;
        end
        en = 1'b0;
        if (!got) begin
            fail_now("run_done");
            exp_q.delete();
            return;
        end
        chk("done_after_last", 64'(prev_last_hs), 64'(1));
        chk("done_pkt_sent", 64'(pkt_sent), 64'(count));
        chk("done_valid", 64'(tvalid), 64'(0));
        chk("done_busy", 64'(busy), 64'(0));
        @(negedge clk);
        chk("done_pulse_width", 64'(done), 64'(0));
        chk("idle_after_done", 64'(busy), 64'(0));
        chk("done_count", 64'(done_seen - d0), 64'(1));
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
    endtask

    // Unlimited run; enable drops after drop_at handshakes (inside the last packet).
    task automatic run_drop(input int len, input int gap, input int npkts, input int drop_at);
        int d0;
        int h0;
        bit got;
        @(negedge clk);
        ready_mode = 1;
        cur_gap    = gap;
        pkt_len    = LW'(len);
        gap_len    = LW'(gap);
        pkt_count  = '0;
        push_run(len, npkts);
        d0 = done_seen;
        h0 = hs_total;
        en = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            #1;
            if (hs_total - h0 >= drop_at) begin
                got = 1'b1;
                break;
            end
        end
        en = 1'b0;
        if (!got) begin
            fail_now("drop_beats");
            exp_q.delete();
            return;
        end
        got = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (!busy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            fail_now("drop_idle");
            exp_q.delete();
            return;
        end
        chk("drop_valid", 64'(tvalid), 64'(0));
        chk("drop_pkt_sent", 64'(pkt_sent), 64'(npkts));
        chk("drop_no_done", 64'(done_seen - d0), 64'(0));
        chk("drop_drained", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic run_reset_mid;
        int h0;
        @(negedge clk);
        ready_mode = 0;
        cur_gap    = 0;
        pkt_len    = 16;
        gap_len    = 0;
        pkt_count  = 1;
        push_run(16, 1);
        h0 = hs_total;
        en = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            #1;
            if (hs_total - h0 >= 3) break;
        end
        rst_n = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 64'(tvalid), 64'(0));
        chk("rst_mid_last", 64'(tlast), 64'(0));
        chk("rst_mid_data", 64'(tdata), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_pkt_sent", 64'(pkt_sent), 64'(0));
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 64'(tvalid), 64'(0));
        chk("reset_last", 64'(tlast), 64'(0));
        chk("reset_data", 64'(tdata), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_pkt_sent", 64'(pkt_sent), 64'(0));
        rst_n = 1'b1;

        run_bounded(4, 0, 1, 0, 1'b0);   // single packet
        run_bounded(3, 0, 1, 2, 1'b0);   // alternating backpressure
        run_bounded(2, 5, 3, 0, 1'b0);   // gap timing
        run_bounded(0, 1, 3, 1, 1'b0);   // zero length behaves as one
        run_drop(8, 0, 1, 2);
        run_drop(3, 2, 3, 8);
        run_reset_mid();
        run_bounded(3, 0, 1, 0, 1'b0);   // payload restarts after reset
        for (int r = 0; r < 16; r++) begin
            run_bounded(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                        int'($urandom_range(1, 3)), int'($urandom_range(0, 2)), 1'b1);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_traffic_gen.md
Name: axis_traffic_gen

Overview:
AXI-Stream packet source for throughput characterisation. It emits packets with a programmable length, inter-packet gap and packet count, and carries a deterministic payload that the bench can check. It drives the link that the team's bit-rate monitor observes, so both ends of a throughput measurement exist on-chip.

Parameters:
DATA_WIDTH, 32, width of o_tdata and of the payload counter
LEN_WIDTH, 16, width of the length, gap and count configuration inputs and of o_pkt_sent

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous reset, active-low
i_en  in  1  run enable; level-sensitive
i_pkt_len  in  LEN_WIDTH  beats per packet; 0 is treated as 1
i_gap_len  in  LEN_WIDTH  idle clocks between packets; 0 means back-to-back
i_pkt_count  in  LEN_WIDTH  packets per run; 0 means unlimited
o_tdata  out  DATA_WIDTH  payload
o_tvalid  out  1  AXIS valid
i_tready  in  1  AXIS ready
o_tlast  out  1  last beat of packet
o_busy  out  1  high whenever state is not IDLE
o_done  out  1  one-cycle pulse when the run completes
o_pkt_sent  out  LEN_WIDTH  packets completed in the current run; wraps at 2^LEN_WIDTH

Behaviour:
- Reset: all outputs are 0. State is IDLE. All internal counters are 0.
- All outputs are registered. A handshake is a cycle with o_tvalid && i_tready.
- States:
  - IDLE: when i_en=1, latch i_pkt_len, i_gap_len and i_pkt_count; clear o_pkt_sent and the payload counter; go to SEND. o_tvalid rises on the next cycle, so latency is one clock.
  - SEND: o_tvalid=1.
    - While i_tready=0, o_tdata and o_tlast are held stable and o_tvalid is not dropped.
    - Each handshake increments the beat and payload counters.
    - o_tlast=1 on beat index len-1.
    - On the last handshake, o_pkt_sent increments.
  - SEND exit on the last handshake:
    - If the run is complete (o_pkt_sent reaches the count, count ≠ 0), pulse o_done and go to IDLE.
    - Otherwise, if i_en=0, go to IDLE without pulsing o_done.
    - Otherwise, if gap=0, stay in SEND with o_tvalid held high continuously.
    - Otherwise, go to GAP.
  - GAP: o_tvalid=0 for exactly gap clocks. Then return to SEND if i_en=1, or go to IDLE if i_en=0.
- The payload counter starts at 0 per run and continues across packets within the run. It wraps modulo 2^DATA_WIDTH.
- Deasserting i_en mid-packet never truncates the packet. The current packet completes with o_tlast, then the block goes to IDLE.
- Configuration inputs are ignored outside IDLE.
- i_pkt_len=1: every beat has o_tlast=1.
- Unlimited mode (count=0): o_done never pulses. o_pkt_sent wraps silently.
- Reset mid-packet: o_tvalid drops in the next cycle. This is the only permitted protocol violation.
- A new run can start from IDLE on the cycle after o_done if i_en is still high. The block then re-latches configuration.

Optional Feature:
- Macro: AXIS_TRAFFIC_GEN_PRBS_EN.
- Defined: o_tdata is driven by a Fibonacci LFSR, polynomial x^31+x^28+1 (PRBS31).
  - Seed is all ones at run start.
  - The LFSR advances one step per handshake.
  - Bits above 31 are the LFSR value replicated; for DATA_WIDTH below 31, o_tdata is the low DATA_WIDTH bits.
- Not defined: o_tdata is the incrementing payload counter. No LFSR logic is synthesised.

Decomposition:
- Package axis_traffic_gen_pkg:
  - state enum type state_t {IDLE, SEND, GAP}
  - PRBS31 tap constants
  - LFSR seed constant
- Sub-module prbs_lfsr: step enable, seed load, DATA_WIDTH output. Instantiated only under AXIS_TRAFFIC_GEN_PRBS_EN.

Test Plan:
- Single packet, no backpressure: len=4, gap=0, count=1, i_tready=1.
  - Response: o_tdata 0,1,2,3 on consecutive cycles; o_tlast on 3; o_done pulses on the cycle after beat 3; o_pkt_sent=1.
- Backpressure: len=3, i_tready low on every other cycle.
  - Response: o_tdata and o_tlast stable while stalled; exactly 3 handshakes; o_tvalid never drops mid-packet.
- Gap timing: len=2, gap=5, count=3, i_tready=1.
  - Response: exactly 5 idle clocks between packets; payload 0..5 across the run; o_done after the 6th beat.
- Enable drop: len=8, unlimited count, i_en low at beat 2.
  - Response: beats 3..7 still sent with o_tlast on 7; block returns to IDLE; no o_done pulse.
- Boundary: len=0.
  - Response: every beat has o_tlast=1.
- Boundary: reset asserted mid-packet.
  - Response: all outputs 0 on the next cycle; next run restarts payload at 0.
- PRBS build: len=4 with AXIS_TRAFFIC_GEN_PRBS_EN.
  - Response: first beat is 0x7FFFFFFF-derived seed value; the sequence matches the reference PRBS31 model.
